// File: rtl/cosim_to_host_serializer_if.sv
// Handshake bundle for the to-host serializer: a message-wide ready/valid input
// channel and a byte-wide ready/valid/last output channel.
interface cosim_to_host_serializer_if #(
  parameter int TO_HOST_SIZE_BITS = 32
);

  logic                         DataInValid;
  logic                         DataInReady;
  logic [TO_HOST_SIZE_BITS-1:0] DataIn;

  logic                         ByteOutValid;
  logic                         ByteOutReady;
  logic [7:0]                   ByteOut;
  logic                         ByteOutLast;

  // Serializer side: accepts messages, produces bytes.
  modport slave (
    input  DataInValid,
    input  DataIn,
    input  ByteOutReady,
    output DataInReady,
    output ByteOutValid,
    output ByteOut,
    output ByteOutLast
  );

  // Environment side: produces messages, consumes bytes.
  modport master (
    output DataInValid,
    output DataIn,
    output ByteOutReady,
    input  DataInReady,
    input  ByteOutValid,
    input  ByteOut,
    input  ByteOutLast
  );

endinterface

// File: rtl/cosim_to_host_serializer.sv
// Splits a packed to-host message into a little-endian byte stream with
// ready/valid/last framing; honours backpressure and never drops a message.
module cosim_to_host_serializer #(
  parameter int TO_HOST_SIZE_BITS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  cosim_to_host_serializer_if.slave    bus
);

  localparam int TO_HOST_SIZE_BYTES = (TO_HOST_SIZE_BITS + 7) / 8;
  localparam int CW                 = (TO_HOST_SIZE_BYTES > 1) ? $clog2(TO_HOST_SIZE_BYTES) : 1;
  localparam int MSG_W              = TO_HOST_SIZE_BYTES * 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(TO_HOST_SIZE_BYTES - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     idx_q,   idx_d;
  logic [MSG_W-1:0]  msg_q,   msg_d;

  logic              sending;
  logic              last_beat;
  logic              beat;
  logic              accept;

  assign sending   = (state_q == SEND);
  assign last_beat = sending && (idx_q == LAST_IDX);
  assign beat      = sending && bus.ByteOutReady;

  // Ready looks only at our own state and downstream ready, never at DataInValid,
  // so a new message can be taken on the same edge the last byte leaves.
  assign bus.DataInReady = !rst && (!sending || (last_beat && bus.ByteOutReady));
  assign accept          = bus.DataInValid && bus.DataInReady;

  assign bus.ByteOutValid = sending;
  assign bus.ByteOutLast  = last_beat;
  assign bus.ByteOut      = sending ? msg_q[7:0] : 8'h00;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    msg_d   = msg_q;

    if (accept) begin
      // Zero-extend so pad bits above the message width read back as 0.
      msg_d                          = '0;
      msg_d[TO_HOST_SIZE_BITS-1:0]   = bus.DataIn;
      idx_d                          = '0;
      state_d                        = SEND;
    end else if (beat) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        msg_d = msg_q >> 8;
        idx_d = idx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the message
    // register is plain flops (not a RAM), so it is safe and cheap to reset.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      msg_q   <= msg_d;
    end
  end

endmodule

// File: tb/tb_cosim_to_host_serializer.sv
// Directed and soak checks of the to-host serializer at 32, 12 and 1 bit widths.
module tb_cosim_to_host_serializer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cosim_to_host_serializer_if #(.TO_HOST_SIZE_BITS(32)) if32 ();
  cosim_to_host_serializer_if #(.TO_HOST_SIZE_BITS(12)) if12 ();
  cosim_to_host_serializer_if #(.TO_HOST_SIZE_BITS(1))  if1  ();

  cosim_to_host_serializer #(.TO_HOST_SIZE_BITS(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
  cosim_to_host_serializer #(.TO_HOST_SIZE_BITS(12)) u_dut12 (.clk(clk), .rst(rst), .bus(if12));
  cosim_to_host_serializer #(.TO_HOST_SIZE_BITS(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the 32-bit instance on the falling edge, then let combinational outputs settle.
  task automatic drive32(input logic dv, input logic [31:0] d, input logic br);
    @(negedge clk);
    if32.DataInValid  = dv;
    if32.DataIn       = d;
    if32.ByteOutReady = br;
    #1;
  endtask

  task automatic expect32(input string tag, input logic v, input logic [7:0] b, input logic l);
    check({tag, ".valid"}, if32.ByteOutValid, v);
    check({tag, ".byte"},  if32.ByteOut,      b);
    check({tag, ".last"},  if32.ByteOutLast,  l);
  endtask

  initial begin
    logic [7:0] basic_b [4];
    logic [7:0] bp_b    [7];
    logic       bp_r    [7];
    logic [7:0] b2b_b   [8];
    logic [7:0] rst_b   [4];
    logic [31:0] q [$];
    logic [31:0] cur;
    logic [31:0] asm_w;
    logic [31:0] exp_w;
    logic        pend;
    logic        prev_stall;
    logic [7:0]  prev_b;
    logic        prev_l;
    int          sent, got, nb, lasts, cycles;

    basic_b = '{8'h78, 8'h56, 8'h34, 8'h12};
    bp_b    = '{8'hD4, 8'hC3, 8'hC3, 8'hC3, 8'hB2, 8'hB2, 8'hA1};
    bp_r    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    b2b_b   = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rst_b   = '{8'h04, 8'h03, 8'h02, 8'h01};

    rst = 1'b1;
    if32.DataInValid = 1'b0; if32.DataIn = '0; if32.ByteOutReady = 1'b0;
    if12.DataInValid = 1'b0; if12.DataIn = '0; if12.ByteOutReady = 1'b0;
    if1.DataInValid  = 1'b0; if1.DataIn  = '0; if1.ByteOutReady  = 1'b0;

    // Reset state.
    drive32(1'b0, 32'h0, 1'b1);
    drive32(1'b1, 32'hFFFF_FFFF, 1'b1);
    check("reset.rdy", if32.DataInReady, 1'b0);
    expect32("reset", 1'b0, 8'h00, 1'b0);
    check("reset.valid12", if12.ByteOutValid, 1'b0);
    check("reset.valid1",  if1.ByteOutValid,  1'b0);
    @(negedge clk);
    if32.DataInValid = 1'b0;
    rst = 1'b0;
    #1;
    check("reset.rdy_after", if32.DataInReady, 1'b1);
    expect32("reset.after", 1'b0, 8'h00, 1'b0);

    // Basic 32-bit message.
    drive32(1'b1, 32'h1234_5678, 1'b1);
    check("basic.rdy_idle", if32.DataInReady, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive32(1'b0, 32'h0, 1'b1);
      expect32($sformatf("basic.b%0d", i), 1'b1, basic_b[i], i == 3);
      check($sformatf("basic.rdy%0d", i), if32.DataInReady, i == 3);
    end
    drive32(1'b0, 32'h0, 1'b1);
    expect32("basic.idle", 1'b0, 8'h00, 1'b0);

    // Backpressure: stalled beats must hold byte and last.
    drive32(1'b1, 32'hA1B2_C3D4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive32(1'b0, 32'h0, bp_r[i]);
      expect32($sformatf("bp.c%0d", i), 1'b1, bp_b[i], i == 6);
    end
    drive32(1'b0, 32'h0, 1'b1);
    expect32("bp.idle", 1'b0, 8'h00, 1'b0);

    // Back-to-back: second message taken on the first message's last beat.
    drive32(1'b1, 32'h1122_3344, 1'b1);
    check("b2b.rdy_idle", if32.DataInReady, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive32(i < 4, 32'hAABB_CCDD, 1'b1);
      expect32($sformatf("b2b.b%0d", i), 1'b1, b2b_b[i], (i == 3) || (i == 7));
      if (i < 4) check($sformatf("b2b.rdy%0d", i), if32.DataInReady, i == 3);
    end
    drive32(1'b0, 32'h0, 1'b1);
    expect32("b2b.idle", 1'b0, 8'h00, 1'b0);

    // Reset mid-message.
    drive32(1'b1, 32'hDEAD_BEEF, 1'b1);
    drive32(1'b0, 32'h0, 1'b1);
    expect32("rstmid.b0", 1'b1, 8'hEF, 1'b0);
    drive32(1'b0, 32'h0, 1'b1);
    expect32("rstmid.b1", 1'b1, 8'hBE, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid.rdy_in_rst", if32.DataInReady, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect32("rstmid.after", 1'b0, 8'h00, 1'b0);
    check("rstmid.rdy_after", if32.DataInReady, 1'b1);
    drive32(1'b1, 32'h0102_0304, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive32(1'b0, 32'h0, 1'b1);
      expect32($sformatf("rstmid.n%0d", i), 1'b1, rst_b[i], i == 3);
    end
    drive32(1'b0, 32'h0, 1'b1);
    expect32("rstmid.idle", 1'b0, 8'h00, 1'b0);

    // 12-bit message: upper byte carries zero padding.
    @(negedge clk);
    if12.DataInValid = 1'b1; if12.DataIn = 12'hABC; if12.ByteOutReady = 1'b1;
    #1;
    check("w12.rdy", if12.DataInReady, 1'b1);
    @(negedge clk);
    if12.DataInValid = 1'b0;
    #1;
    check("w12.b0.valid", if12.ByteOutValid, 1'b1);
    check("w12.b0.byte",  if12.ByteOut,      8'hBC);
    check("w12.b0.last",  if12.ByteOutLast,  1'b0);
    @(negedge clk);
    #1;
    check("w12.b1.valid", if12.ByteOutValid, 1'b1);
    check("w12.b1.byte",  if12.ByteOut,      8'h0A);
    check("w12.b1.last",  if12.ByteOutLast,  1'b1);
    @(negedge clk);
    #1;
    check("w12.idle", if12.ByteOutValid, 1'b0);

    // 1-bit message: a single beat that is always last.
    @(negedge clk);
    if1.DataInValid = 1'b1; if1.DataIn = 1'b1; if1.ByteOutReady = 1'b1;
    #1;
    check("w1.rdy", if1.DataInReady, 1'b1);
    @(negedge clk);
    if1.DataInValid = 1'b0;
    #1;
    check("w1.valid", if1.ByteOutValid, 1'b1);
    check("w1.byte",  if1.ByteOut,      8'h01);
    check("w1.last",  if1.ByteOutLast,  1'b1);
    check("w1.rdy_last", if1.DataInReady, 1'b1);
    @(negedge clk);
    #1;
    check("w1.idle", if1.ByteOutValid, 1'b0);

    // Random soak with a reassembly scoreboard.
    sent = 0; got = 0; nb = 0; lasts = 0; cycles = 0;
    pend = 1'b0; prev_stall = 1'b0; prev_b = '0; prev_l = 1'b0;
    asm_w = '0; cur = '0;
    while (got < 1000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        cur  = $urandom;
        pend = 1'b1;
      end
      if32.DataInValid  = pend;
      if32.DataIn       = cur;
      if32.ByteOutReady = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        check("soak.hold_valid", if32.ByteOutValid, 1'b1);
        check("soak.hold_byte",  if32.ByteOut,      prev_b);
        check("soak.hold_last",  if32.ByteOutLast,  prev_l);
      end
      if (if32.DataInValid && if32.DataInReady) begin
        q.push_back(cur);
        pend = 1'b0;
        sent++;
      end
      if (if32.ByteOutValid && if32.ByteOutReady) begin
        asm_w = asm_w | (32'(if32.ByteOut) << (8 * nb));
        nb++;
        if (if32.ByteOutLast) begin
          check("soak.len", nb, 4);
          if (q.size() == 0) begin
            check("soak.unexpected_msg", 1'b1, 1'b0);
          end else begin
            exp_w = q.pop_front();
            check($sformatf("soak.msg%0d", got), asm_w, exp_w);
          end
          lasts++;
          got++;
          nb    = 0;
          asm_w = '0;
        end
      end
      prev_stall = if32.ByteOutValid && !if32.ByteOutReady;
      prev_b     = if32.ByteOut;
      prev_l     = if32.ByteOutLast;
    end
    check("soak.in_time", cycles < 40000, 1'b1);
    check("soak.last_count", lasts, 1000);
    check("soak.sent_count", sent, 1000);
    check("soak.queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
